hw_accel_cmd_ctrl: RTL and testbench

// Register-mapped command controller between the AXI4 slave's user-logic port (usr_*) and one compute engine.

---
 rtl/hw_accel_cmd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hw_accel_cmd_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_accel_cmd_ctrl.sv
// Register-mapped command controller: decodes CPU writes, launches one compute engine,
// times it, captures the result and raises a level interrupt; serves single-beat reads.
module hw_accel_cmd_ctrl #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RST = 32'h000F_4240
) (
  input  logic                    axi_aclk,
  input  logic                    axi_reset,
  input  logic                    usr_we,
  input  logic [ADDR_WIDTH-1:0]   usr_waddr,
  input  logic [DATA_WIDTH-1:0]   usr_wdata,
  input  logic                    usr_re,
  input  logic [ADDR_WIDTH-1:0]   usr_raddr,
  output logic [DATA_WIDTH-1:0]   usr_rdata,
  output logic                    usr_rvalid,
  output logic                    eng_start_valid,
  input  logic                    eng_start_ready,
  output logic [4*DATA_WIDTH-1:0] eng_args,
  input  logic                    eng_done,
  input  logic [DATA_WIDTH-1:0]   eng_result,
  output logic                    eng_abort,
  output logic                    irq
);

  // state | meaning
  // IDLE  | no operation in flight, START accepted
  // ISSUE | start request presented, waiting for eng_start_ready
  // RUN   | engine running, CYCLES counting, watching done/timeout
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [3:0] A_CTRL    = 4'd0;
  localparam logic [3:0] A_STATUS  = 4'd1;
  localparam logic [3:0] A_ARG0    = 4'd2;
  localparam logic [3:0] A_ARG1    = 4'd3;
  localparam logic [3:0] A_ARG2    = 4'd4;
  localparam logic [3:0] A_ARG3    = 4'd5;
  localparam logic [3:0] A_RESULT  = 4'd6;
  localparam logic [3:0] A_CYCLES  = 4'd7;
  localparam logic [3:0] A_TIMEOUT = 4'd8;

  state_t state, state_nxt;

  logic                  irq_en;
  logic                  flag_done, flag_timeout, flag_overrun;
  logic [DATA_WIDTH-1:0] arg0, arg1, arg2, arg3;
  logic [DATA_WIDTH-1:0] result, cycles, timeout;
  logic                  re_q;
  logic [DATA_WIDTH-1:0] rd_mux;

  logic [3:0] widx, ridx;
  logic       wr_ctrl, wr_status, start_go, busy, to_hit, done_hit, abort_hit;
  logic       unused_addr;

  assign widx        = usr_waddr[5:2];
  assign ridx        = usr_raddr[5:2];
  assign unused_addr = ^{usr_waddr[ADDR_WIDTH-1:6], usr_waddr[1:0],
                         usr_raddr[ADDR_WIDTH-1:6], usr_raddr[1:0]};

  assign busy      = (state != ST_IDLE);
  assign wr_ctrl   = usr_we && (widx == A_CTRL);
  assign wr_status = usr_we && (widx == A_STATUS);
  assign start_go  = wr_ctrl && usr_wdata[0] && !busy;
  assign to_hit    = (timeout != '0) && (cycles == timeout - DATA_WIDTH'(1));
  assign done_hit  = (state == ST_RUN) && eng_done;
  // done wins over a coincident timeout; reset suppresses the abort pulse
  assign abort_hit = (state == ST_RUN) && !eng_done && to_hit && !axi_reset;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    eng_start_valid = 1'b0;
    eng_abort       = 1'b0;
    case (state)
      ST_IDLE:  if (start_go) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        eng_start_valid = 1'b1;
        if (eng_start_ready) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (eng_done) begin
          state_nxt = ST_IDLE;
        end else if (abort_hit) begin
          eng_abort = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      irq_en       <= 1'b0;
      flag_done    <= 1'b0;
      flag_timeout <= 1'b0;
      flag_overrun <= 1'b0;
      arg0         <= '0;
      arg1         <= '0;
      arg2         <= '0;
      arg3         <= '0;
      result       <= '0;
      cycles       <= '0;
      timeout      <= TIMEOUT_RST;
      eng_args     <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= usr_wdata[1];
      if (usr_we) begin
        case (widx)
          A_ARG0:    arg0    <= usr_wdata;
          A_ARG1:    arg1    <= usr_wdata;
          A_ARG2:    arg2    <= usr_wdata;
          A_ARG3:    arg3    <= usr_wdata;
          A_TIMEOUT: timeout <= usr_wdata;
          default: ;
        endcase
      end
      if (start_go) begin
        eng_args <= {arg3, arg2, arg1, arg0};
        cycles   <= '0;
      end else if ((state == ST_RUN) && (cycles != '1)) begin
        cycles <= cycles + DATA_WIDTH'(1);
      end
      if (done_hit) result <= eng_result;
      // hardware set beats a coincident W1C
      flag_done    <= done_hit  | (flag_done    & ~(wr_status & usr_wdata[1]));
      flag_timeout <= abort_hit | (flag_timeout & ~(wr_status & usr_wdata[2]));
      flag_overrun <= (wr_ctrl & usr_wdata[0] & busy)
                    | (flag_overrun & ~(wr_status & usr_wdata[3]));
      irq <= irq_en & (flag_done | flag_timeout | flag_overrun);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ridx)
      A_CTRL:    rd_mux = {{(DATA_WIDTH-2){1'b0}}, irq_en, 1'b0};
      A_STATUS:  rd_mux = {{(DATA_WIDTH-4){1'b0}}, flag_overrun, flag_timeout, flag_done, busy};
      A_ARG0:    rd_mux = arg0;
      A_ARG1:    rd_mux = arg1;
      A_ARG2:    rd_mux = arg2;
      A_ARG3:    rd_mux = arg3;
      A_RESULT:  rd_mux = result;
      A_CYCLES:  rd_mux = cycles;
      A_TIMEOUT: rd_mux = timeout;
      default:   rd_mux = '0;
    endcase
  end

  // one read pulse per rising edge of the usr_re level
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      re_q       <= 1'b0;
      usr_rvalid <= 1'b0;
      usr_rdata  <= '0;
    end else begin
      re_q       <= usr_re;
      usr_rvalid <= 1'b0;
      if (usr_re && !re_q) begin
        usr_rvalid <= 1'b1;
        usr_rdata  <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_hw_accel_cmd_ctrl.sv
// Scoreboard bench for hw_accel_cmd_ctrl: directed scenarios plus randomized operations
// checked against a register-level reference model.
module tb_hw_accel_cmd_ctrl;
  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam logic [31:0] TO_RST = 32'h000F_4240;

  logic          clk = 1'b0;
  logic          rst;
  logic          usr_we, usr_re;
  logic [AW-1:0] usr_waddr, usr_raddr;
  logic [DW-1:0] usr_wdata, usr_rdata;
  logic          usr_rvalid;
  logic          eng_start_valid, eng_start_ready;
  logic [4*DW-1:0] eng_args;
  logic          eng_done, eng_abort, irq;
  logic [DW-1:0] eng_result;

  hw_accel_cmd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_RST(TO_RST)) dut (
    .axi_aclk(clk), .axi_reset(rst),
    .usr_we(usr_we), .usr_waddr(usr_waddr), .usr_wdata(usr_wdata),
    .usr_re(usr_re), .usr_raddr(usr_raddr), .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid),
    .eng_start_valid(eng_start_valid), .eng_start_ready(eng_start_ready),
    .eng_args(eng_args), .eng_done(eng_done), .eng_result(eng_result),
    .eng_abort(eng_abort), .irq(irq)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
    string       name;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  // reference model of the register file
  logic [31:0]  m_arg[4];
  logic [127:0] m_eargs;
  logic [31:0]  m_result, m_cycles, m_timeout;
  bit           m_irq_en, m_done, m_to, m_ovr, m_busy;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    if (usr_rvalid) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_data"}, usr_rdata, e.data);
        check({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] baddr(int idx);
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_FFC0) | (32'(idx) << 2) | ($urandom & 32'h3);
    return a;
  endfunction

  function automatic logic [31:0] exp_reg(int idx);
    case (idx)
      0: return {30'b0, m_irq_en, 1'b0};
      1: return {28'b0, m_ovr, m_to, m_done, m_busy};
      2, 3, 4, 5: return m_arg[idx-2];
      6: return m_result;
      7: return m_cycles;
      8: return m_timeout;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_arg[k] = '0;
    m_eargs = '0; m_result = '0; m_cycles = '0; m_timeout = TO_RST;
    m_irq_en = 0; m_done = 0; m_to = 0; m_ovr = 0; m_busy = 0;
  endtask

  task automatic wr(int idx, logic [31:0] d);
    case (idx)
      0: begin
        m_irq_en = d[1];
        if (d[0]) begin
          if (m_busy) m_ovr = 1;
          else begin
            m_eargs  = {m_arg[3], m_arg[2], m_arg[1], m_arg[0]};
            m_cycles = '0;
            m_busy   = 1;
          end
        end
      end
      1: begin
        if (d[1]) m_done = 0;
        if (d[2]) m_to   = 0;
        if (d[3]) m_ovr  = 0;
      end
      2, 3, 4, 5: m_arg[idx-2] = d;
      8: m_timeout = d;
      default: ;
    endcase
    usr_we = 1; usr_waddr = baddr(idx); usr_wdata = d;
    tick();
    usr_we = 0;
  endtask

  task automatic rd(int idx, int hold, string name);
    rd_exp_t e;
    e.data = exp_reg(idx);
    e.cyc  = cyc + 1;
    e.name = name;
    exp_q.push_back(e);
    usr_re = 1; usr_raddr = baddr(idx);
    repeat (hold) tick();
    usr_re = 0;
    tick();
  endtask

  // Engine behaviour: ready after rdly cycles, done on RUN cycle d (0 = never).
  task automatic run_engine(int rdly, int d, logic [31:0] res, bit w1c_done);
    int end_j;
    bit aborted;
    check("start_valid", eng_start_valid, 1);
    repeat (rdly) tick();
    check("start_valid_held", eng_start_valid, 1);
    eng_start_ready = 1;
    tick();
    eng_start_ready = 0;
    if (m_timeout != 0 && (d == 0 || 32'(d) > m_timeout)) begin
      end_j = int'(m_timeout); aborted = 1;
    end else begin
      end_j = d; aborted = 0;
    end
    if (end_j == 0 || end_j > 300) begin
      $display("FAIL engine_bound: run length %0d out of range", end_j);
      n_fail++; n_tests++;
      end_j = 300;
    end
    for (int j = 1; j <= end_j; j++) begin
      if (j == d) begin
        eng_done = 1; eng_result = res;
        if (w1c_done) begin usr_we = 1; usr_waddr = baddr(1); usr_wdata = 32'h2; end
      end
      #1;
      check("eng_abort", eng_abort, (aborted && j == end_j));
      tick();
      eng_done = 0; usr_we = 0; eng_result = $urandom;
    end
    m_busy = 0;
    if (aborted) begin m_to = 1; m_cycles = 32'(end_j); end
    else begin m_done = 1; m_result = res; m_cycles = 32'(d); end
  endtask

  task automatic check_irq();
    tick();
    check("irq", irq, m_irq_en & (m_done | m_to | m_ovr));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_rvalid"}, usr_rvalid, 0);
    check({tag, "_rdata"}, usr_rdata, 0);
    check({tag, "_start_valid"}, eng_start_valid, 0);
    check({tag, "_abort"}, eng_abort, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_eng_args"}, eng_args, 0);
  endtask

  initial begin
    int idx;
    rst = 1; usr_we = 0; usr_re = 0; usr_waddr = 0; usr_raddr = 0; usr_wdata = 0;
    eng_start_ready = 0; eng_done = 0; eng_result = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 0;
    model_reset();
    rd(8, 1, "rst_timeout");
    rd(1, 2, "rst_status");

    // basic operation
    wr(2, 32'h11); wr(3, 32'h22); wr(0, 32'h3);
    check("t1_eng_args", eng_args, m_eargs);
    run_engine(2, 10, 32'hCAFE, 0);
    check("t1_irq_lag", irq, 0);
    check_irq();
    rd(6, 1, "t1_result"); rd(7, 1, "t1_cycles"); rd(1, 1, "t1_status");

    // timeout with an engine that never finishes
    wr(1, 32'hF); wr(8, 5); wr(0, 32'h3);
    run_engine(1, 0, $urandom, 0);
    check_irq();
    rd(1, 1, "t2_status"); rd(7, 1, "t2_cycles");

    // overrun and ARG writes while busy
    wr(1, 32'hF); wr(8, 0); wr(2, 32'hA5); wr(0, 32'h1);
    wr(2, 32'h5A); wr(0, 32'h1);
    check("t3_eng_args_frozen", eng_args, m_eargs);
    run_engine(0, 4, 32'h1234, 0);
    rd(1, 1, "t3_status_ovr"); wr(1, 32'h8); rd(1, 1, "t3_status_w1c"); rd(2, 1, "t3_arg0");

    // held read level gives exactly one pulse
    rd(6, 6, "t4_hold_result");

    // done coincident with timeout, then done coincident with W1C
    wr(1, 32'hF); wr(8, 7); wr(0, 32'h3);
    run_engine(0, 7, 32'hBEEF, 0);
    rd(1, 1, "t5_status_tie"); rd(7, 1, "t5_cycles_tie");
    wr(0, 32'h1);
    run_engine(1, 3, 32'h77, 1);
    rd(1, 1, "t5_status_w1c"); rd(6, 1, "t5_result_w1c");

    // reset during RUN
    wr(8, 20); wr(2, 32'h99); wr(0, 32'h3);
    eng_start_ready = 1; tick(); eng_start_ready = 0;
    repeat (3) tick();
    rst = 1; tick();
    check_reset_outputs("t6_midrun");
    rst = 0; model_reset();
    rd(8, 1, "t6_timeout"); rd(1, 1, "t6_status"); rd(2, 1, "t6_arg0");
    wr(2, 32'h42); wr(0, 32'h1);
    check("t6_eng_args", eng_args, m_eargs);
    run_engine(0, 6, 32'hD00D, 0);
    rd(6, 1, "t6_result"); rd(7, 1, "t6_cycles"); rd(1, 1, "t6_status_done");

    // randomized operations
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 4; k++) if ($urandom % 2 == 1) wr(2 + k, $urandom);
      idx = ($urandom % 2 == 1) ? 6 + int'($urandom % 2) : int'($urandom_range(9, 15));
      wr(idx, $urandom);
      wr(8, ($urandom % 3 == 0) ? 32'h0 : 32'($urandom_range(1, 12)));
      wr(0, {30'b0, 1'($urandom % 2), 1'b1});
      check("rand_eng_args", eng_args, m_eargs);
      run_engine(int'($urandom_range(0, 3)), int'($urandom_range(1, 15)), $urandom, ($urandom % 4 == 0));
      check_irq();
      for (int r = 0; r < 3; r++) rd(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)), "rand_read");
      wr(1, $urandom & 32'hF);
      rd(1, 1, "rand_status");
      check_irq();
    end

    repeat (3) tick();
    check("rd_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
